// File: rtl/control.sv
// control: registered main decoder for the KGP-RISC datapath.
// Define CONTROL_ILLEGAL_FLAG_EN to add the registered 'illegal' output for undefined encodings.
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [4:0] funccode,
    output logic       regWrite,
    output logic       memToReg,
    output logic       memRead,
    output logic       memWrite,
    output logic [1:0] ALUSrc,
    output logic [1:0] ALUOp,
    output logic       ALUFrc,
    output logic [2:0] branch,
    output logic       brLink
`ifdef CONTROL_ILLEGAL_FLAG_EN
    ,
    output logic       illegal
`endif
);
    // packing: {regWrite, memToReg, memRead, memWrite, ALUSrc, ALUOp, ALUFrc, branch, brLink}
    logic [13:0] w_ctl;
    logic [13:0] r_ctl;
    always_comb begin
        w_ctl = '0;
        case (opcode)
            5'd0: w_ctl = (funccode <= 5'd9) ? {4'b1000,
                          (funccode == 5'd4 || funccode == 5'd5 || funccode == 5'd8) ? 2'b10 : 2'b00,
                          2'b00, funccode <= 5'd1, 4'b0000} : '0;
            5'd1: w_ctl = (funccode <= 5'd1) ? 14'b1000_01_01_1_000_0 : '0;
            5'd2: w_ctl = (funccode == 5'd0) ? 14'b1110_01_10_0_000_0 :
                          (funccode == 5'd1) ? 14'b0001_01_10_0_000_0 : '0;
            5'd3: w_ctl = (funccode == 5'd0) ? 14'b0000_00_11_0_010_0 : '0;
            5'd4: w_ctl = (funccode <= 5'd2) ? {8'b0000_00_11, 1'b0, funccode[2:0] + 3'd3, 1'b0} : '0;
            5'd5: w_ctl = (funccode <= 5'd3) ? {funccode == 5'd1, 7'b000_00_11, 1'b0,
                          funccode[1] ? {2'b11, funccode[0]} : 3'b001, funccode == 5'd1} : '0;
            default: w_ctl = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ctl <= '0;
        else     r_ctl <= w_ctl;
    assign {regWrite, memToReg, memRead, memWrite, ALUSrc, ALUOp, ALUFrc, branch, brLink} = r_ctl;
`ifdef CONTROL_ILLEGAL_FLAG_EN
    // every legal encoding asserts at least one control bit, so an all-zero decode marks the undefined set
    logic r_ill;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ill <= 1'b0;
        else     r_ill <= (w_ctl == '0);
    assign illegal = r_ill;
`endif
endmodule

// File: tb/tb_control.sv
// tb_control: scoreboard bench for the control decoder with directed, hand-computed vectors.
module tb_control;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] opcode = '0;
    logic [4:0] funccode = '0;
    logic       regWrite, memToReg, memRead, memWrite, ALUFrc, brLink;
    logic [1:0] ALUSrc, ALUOp;
    logic [2:0] branch;
    logic       dut_ill;
    logic [13:0] act;
    int total = 0;
    int bad = 0;

    typedef struct { int id; logic ill; logic [13:0] ctl; } exp_t;
    exp_t sb[$];

    control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funccode(funccode),
        .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ALUFrc(ALUFrc), .branch(branch), .brLink(brLink)
`ifdef CONTROL_ILLEGAL_FLAG_EN
        , .illegal(dut_ill)
`endif
    );
`ifdef CONTROL_ILLEGAL_FLAG_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
    assign dut_ill = 1'b0;
`endif

    assign act = {regWrite, memToReg, memRead, memWrite, ALUSrc, ALUOp, ALUFrc, branch, brLink};

    always #5 clk = ~clk;

    // monitor: each edge out of reset presents one decode; compare it with the oldest expectation
    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.ctl || dut_ill !== (e.ill & ILL_EN)) begin
                bad++;
                $display("FAIL vec%0d: got ctl=%b ill=%b, want ctl=%b ill=%b",
                         e.id, act, dut_ill, e.ctl, e.ill & ILL_EN);
            end
        end
    end

    int vid = 0;
    task automatic issue(input logic [4:0] op, input logic [4:0] f, input logic ill, input logic [13:0] ctl);
        exp_t e;
        @(negedge clk);
        opcode = op;
        funccode = f;
        e.id = vid++;
        e.ill = ill;
        e.ctl = ctl;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        total++;
        if (act !== 14'b0 || dut_ill !== 1'b0) begin
            bad++;
            $display("FAIL %s: got ctl=%b ill=%b, want all zero", name, act, dut_ill);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 chk_zero("rst_init");
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_init_hold");
        @(negedge clk);
        rst = 1'b0;
        // op 0 sweep: shifts by shamt use ALUSrc=10, only add/comp update flags
        issue(0, 0, 0, 14'b1000_00_00_1_000_0);
        issue(0, 1, 0, 14'b1000_00_00_1_000_0);
        issue(0, 2, 0, 14'b1000_00_00_0_000_0);
        issue(0, 3, 0, 14'b1000_00_00_0_000_0);
        issue(0, 4, 0, 14'b1000_10_00_0_000_0);
        issue(0, 5, 0, 14'b1000_10_00_0_000_0);
        issue(0, 6, 0, 14'b1000_00_00_0_000_0);
        issue(0, 7, 0, 14'b1000_00_00_0_000_0);
        issue(0, 8, 0, 14'b1000_10_00_0_000_0);
        issue(0, 9, 0, 14'b1000_00_00_0_000_0);
        issue(2, 0, 0, 14'b1110_01_10_0_000_0);
        issue(2, 1, 0, 14'b0001_01_10_0_000_0);
        issue(1, 0, 0, 14'b1000_01_01_1_000_0);
        issue(1, 1, 0, 14'b1000_01_01_1_000_0);
        issue(3, 0, 0, 14'b0000_00_11_0_010_0);
        issue(4, 0, 0, 14'b0000_00_11_0_011_0);
        issue(4, 1, 0, 14'b0000_00_11_0_100_0);
        issue(4, 2, 0, 14'b0000_00_11_0_101_0);
        issue(5, 0, 0, 14'b0000_00_11_0_001_0);
        issue(5, 1, 0, 14'b1000_00_11_0_001_1);
        issue(5, 2, 0, 14'b0000_00_11_0_110_0);
        issue(5, 3, 0, 14'b0000_00_11_0_111_0);
        issue(4, 3, 1, 14'b0);
        issue(0, 10, 1, 14'b0);
        issue(7, 0, 1, 14'b0);
        issue(1, 2, 1, 14'b0);
        issue(3, 1, 1, 14'b0);
        issue(31, 31, 1, 14'b0);
        issue(2, 0, 0, 14'b1110_01_10_0_000_0);
        drain();
        // mid-stream reset: the pending bl decode must be discarded
        @(negedge clk);
        opcode = 5'd5;
        funccode = 5'd1;
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        @(posedge clk);
        #1 chk_zero("rst_hold_edge");
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero("rst_release_pre_edge");
        begin
            exp_t e;
            e.id = vid++;
            e.ill = 1'b0;
            e.ctl = 14'b1000_00_11_0_001_1;
            sb.push_back(e);
        end
        drain();
        issue(0, 4, 0, 14'b1000_10_00_0_000_0);
        issue(6, 0, 1, 14'b0);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
